// File: rtl/cnn_bit_packer_if.sv
// ---------------------------------------------------------------------------
// cnn_bit_packer_if
// Byte handshake between the bit packer and the UART transmitter.
//   trmt    : one-cycle request, the byte on tx_data is to be sent
//   tx_data : byte to transmit, held by the packer until after tx_done
//   tx_done : one-cycle pulse from the UART, current byte finished
// master = packer side, slave = UART side.
// ---------------------------------------------------------------------------
interface cnn_bit_packer_if;
    logic       trmt;
    logic [7:0] tx_data;
    logic       tx_done;

    modport master (
        output trmt,
        output tx_data,
        input  tx_done
    );

    modport slave (
        input  trmt,
        input  tx_data,
        output tx_done
    );
endinterface

// File: rtl/cnn_bit_packer.sv
// ---------------------------------------------------------------------------
// cnn_bit_packer
// Reads a 1-bit-wide synchronous RAM from address 0 upward, packs every 8
// bits into a byte (RAM address 8k+i -> bit i of byte k, LSB first) and hands
// each byte to the UART with a trmt/tx_done handshake. A partial final byte
// is zero-padded in its upper bits.
//
// Parameters:
//   NUM_BITS : number of RAM bits to dump (1..1024)
//   ADDR_W   : RAM address width
// Ports:
//   clk     in   system clock
//   rst_n   in   synchronous active-low reset
//   strt    in   start pulse, only looked at while idle
//   addr_rd out  RAM read address (registered)
//   din     in   RAM read data, valid the cycle after addr_rd
//   bsy     out  high whenever a dump is in progress
//   done    out  one-cycle pulse after the final byte's tx_done
//   tx_if   master side of the UART byte handshake (trmt, tx_data, tx_done)
// ---------------------------------------------------------------------------
module cnn_bit_packer #(
    parameter int NUM_BITS = 784,
    parameter int ADDR_W   = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  strt,
    output logic [ADDR_W-1:0]     addr_rd,
    input  logic                  din,
    output logic                  bsy,
    output logic                  done,
    cnn_bit_packer_if.master      tx_if
);

    // One extra bit so the counter can reach NUM_BITS (e.g. 1024 with a
    // 10-bit RAM address) without wrapping to 0.
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(NUM_BITS - 1);
    localparam logic [CNT_W-1:0] END_ADDR  = CNT_W'(NUM_BITS);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CAP,
        XMIT,
        WAIT
    } state_t;

    state_t           state_q,    state_d;
    logic [CNT_W-1:0] bit_addr_q, bit_addr_d;
    logic [2:0]       cnt_8_q,    cnt_8_d;
    logic [7:0]       shreg_q,    shreg_d;
    logic [7:0]       tx_data_q,  tx_data_d;
    logic             done_q,     done_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bit_addr_q <= '0;
            cnt_8_q    <= '0;
            shreg_q    <= '0;
            tx_data_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_addr_q <= bit_addr_d;
            cnt_8_q    <= cnt_8_d;
            shreg_q    <= shreg_d;
            tx_data_q  <= tx_data_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_addr_d = bit_addr_q;
        cnt_8_d    = cnt_8_q;
        shreg_d    = shreg_q;
        tx_data_d  = tx_data_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (strt) begin
                    bit_addr_d = '0;
                    cnt_8_d    = '0;
                    shreg_d    = '0;
                    state_d    = READ;
                end
            end

            // Address is on addr_rd this cycle; RAM data arrives next cycle.
            READ: state_d = CAP;

            CAP: begin
                shreg_d[cnt_8_q] = din;
                bit_addr_d       = bit_addr_q + CNT_W'(1);
                cnt_8_d          = cnt_8_q + 3'd1;
                // Byte is complete on its 8th bit or on the last RAM bit;
                // the captured bit must be part of the transmitted byte.
                if (cnt_8_q == 3'd7 || bit_addr_q == LAST_ADDR) begin
                    tx_data_d = shreg_d;
                    state_d   = XMIT;
                end else begin
                    state_d = READ;
                end
            end

            XMIT: state_d = WAIT;

            WAIT: begin
                if (tx_if.tx_done) begin
                    if (bit_addr_q == END_ADDR) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_8_d = '0;
                        shreg_d = '0;
                        state_d = READ;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign addr_rd       = bit_addr_q[ADDR_W-1:0];
    assign tx_if.trmt    = (state_q == XMIT);
    assign tx_if.tx_data = tx_data_q;
    assign bsy           = (state_q != IDLE);
    assign done          = done_q;

endmodule

// File: tb/tb_cnn_bit_packer.sv
// ---------------------------------------------------------------------------
// tb_cnn_bit_packer
// Directed bench for cnn_bit_packer. Two instances: dut_a dumps 784 bits
// (A5/3C pattern, byte 0 first set to 0x01), dut_b dumps 20 bits of ones.
// Each has a synchronous 1-bit RAM model and a UART responder returning
// tx_done a fixed number of cycles after trmt.
// ---------------------------------------------------------------------------
module tb_cnn_bit_packer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       strt_a, strt_b;
    logic       din_a, din_b;
    logic [9:0] addr_a, addr_b;
    logic       bsy_a, bsy_b, done_a, done_b;
    logic       uart_done_a, uart_done_b, spur_a;
    int         dly_a = 10;

    logic ram_a [0:1023];
    logic ram_b [0:1023];

    cnn_bit_packer_if ifa ();
    cnn_bit_packer_if ifb ();

    assign ifa.tx_done = uart_done_a | spur_a;
    assign ifb.tx_done = uart_done_b;

    cnn_bit_packer #(.NUM_BITS(784), .ADDR_W(10)) dut_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .strt    (strt_a),
        .addr_rd (addr_a),
        .din     (din_a),
        .bsy     (bsy_a),
        .done    (done_a),
        .tx_if   (ifa)
    );

    cnn_bit_packer #(.NUM_BITS(20), .ADDR_W(10)) dut_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .strt    (strt_b),
        .addr_rd (addr_b),
        .din     (din_b),
        .bsy     (bsy_b),
        .done    (done_b),
        .tx_if   (ifb)
    );

    // Synchronous RAMs: data follows the address by one cycle.
    always @(posedge clk) begin
        din_a <= ram_a[addr_a];
        din_b <= ram_b[addr_b];
    end

    // Byte / done monitors.
    logic [7:0] bytes_a [$];
    logic [7:0] bytes_b [$];
    int         ndone_a = 0;

    always @(negedge clk) begin
        if (ifa.trmt === 1'b1) bytes_a.push_back(ifa.tx_data);
        if (ifb.trmt === 1'b1) bytes_b.push_back(ifb.tx_data);
        if (done_a === 1'b1) ndone_a <= ndone_a + 1;
    end

    // UART responders: tx_done in the cycle dly after the trmt cycle.
    initial begin
        uart_done_a = 1'b0;
        forever begin
            @(negedge clk);
            if (ifa.trmt === 1'b1) begin
                repeat (dly_a) @(negedge clk);
                uart_done_a = 1'b1;
                @(negedge clk);
                uart_done_a = 1'b0;
            end
        end
    end

    initial begin
        uart_done_b = 1'b0;
        forever begin
            @(negedge clk);
            if (ifb.trmt === 1'b1) begin
                repeat (10) @(negedge clk);
                uart_done_b = 1'b1;
                @(negedge clk);
                uart_done_b = 1'b0;
            end
        end
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Waits for the next trmt cycle; returns the number of negedges waited,
    // or -1 if none arrived within the limit.
    task automatic wait_trmt(input bit sel_b, input int limit, output int waited);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (((sel_b ? ifb.trmt : ifa.trmt) !== 1'b1) && waited < limit);
        if ((sel_b ? ifb.trmt : ifa.trmt) !== 1'b1) waited = -1;
    endtask

    task automatic set_byte_a(input int k, input logic [7:0] v);
        for (int i = 0; i < 8; i++) ram_a[8*k + i] = v[i];
    endtask

    initial begin
        int         w;
        int         base;
        int         bad;
        int         nd0;
        int         seen;
        logic [7:0] held;
        logic [7:0] expb;

        rst_n  = 1'b0;
        strt_a = 1'b0;
        strt_b = 1'b0;
        spur_a = 1'b0;
        for (int k = 0; k < 128; k++) set_byte_a(k, (k % 2 == 0) ? 8'hA5 : 8'h3C);
        set_byte_a(0, 8'h01);
        for (int i = 0; i < 1024; i++) ram_b[i] = (i < 20);

        // ---------------- reset values
        repeat (3) @(negedge clk);
        chk("rst_addr",    32'(addr_a),      0);
        chk("rst_txdata",  32'(ifa.tx_data), 0);
        chk("rst_trmt",    32'(ifa.trmt),    0);
        chk("rst_bsy",     32'(bsy_a),       0);
        chk("rst_done",    32'(done_a),      0);
        chk("rst_bsy_b",   32'(bsy_b),       0);
        rst_n = 1'b1;
        @(negedge clk);

        // ---------------- cycle-accurate first byte (byte 0 = 0x01)
        strt_a = 1'b1;
        @(negedge clk);                 // cycle 1
        strt_a = 1'b0;
        chk("c1_bsy", 32'(bsy_a), 1);
        for (int c = 1; c <= 17; c++) begin
            if (c > 1) @(negedge clk);
            if (c % 2 == 1 && c <= 15) chk($sformatf("addr_c%0d", c), 32'(addr_a), 32'((c - 1) / 2));
            if (c == 16) chk("trmt_c16", 32'(ifa.trmt), 0);
        end
        chk("trmt_c17",   32'(ifa.trmt),    1);
        chk("byte0_data", 32'(ifa.tx_data), 32'h01);

        // tx_done 10 cycles after trmt, next trmt 17 cycles after tx_done
        wait_trmt(1'b0, 100, w);
        chk("gap_b1",  32'(w), 27);
        chk("b1_data", 32'(ifa.tx_data), 32'h3C);
        wait_trmt(1'b0, 100, w);
        chk("gap_b2",  32'(w), 27);
        chk("b2_data", 32'(ifa.tx_data), 32'hA5);

        // ---------------- reset during CAP of byte 3 (bit 0)
        repeat (12) @(negedge clk);
        chk("cap3_addr", 32'(addr_a), 24);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rst_addr",   32'(addr_a),      0);
        chk("mid_rst_txdata", 32'(ifa.tx_data), 0);
        chk("mid_rst_trmt",   32'(ifa.trmt),    0);
        chk("mid_rst_bsy",    32'(bsy_a),       0);
        chk("mid_rst_done",   32'(done_a),      0);
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (ifa.trmt === 1'b1) seen++;
        end
        chk("no_trmt_after_rst", 32'(seen), 0);

        // ---------------- full 784-bit dump with stray strt / tx_done
        set_byte_a(0, 8'hA5);
        base = bytes_a.size();
        nd0  = ndone_a;
        strt_a = 1'b1;
        @(negedge clk);
        strt_a = 1'b0;
        chk("restart_addr", 32'(addr_a), 0);
        chk("restart_bsy",  32'(bsy_a),  1);
        seen = 0;
        for (int b = 0; b < 98; b++) begin
            wait_trmt(1'b0, 200, w);
            if (w < 0) break;
            seen++;
            if (b == 5) begin
                // strt while waiting on byte 5
                repeat (3) @(negedge clk);
                strt_a = 1'b1;
                @(negedge clk);
                strt_a = 1'b0;
            end else if (b == 6) begin
                // tx_done during the XMIT cycle itself
                spur_a = 1'b1;
                @(negedge clk);
                spur_a = 1'b0;
            end else if (b == 7) begin
                // tx_done during READ and CAP of byte 8's first bit
                repeat (11) @(negedge clk);
                spur_a = 1'b1;
                repeat (2) @(negedge clk);
                spur_a = 1'b0;
            end
        end
        chk("dump_trmt_count", 32'(seen), 98);
        w = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done_a === 1'b1) begin
                w = i;
                break;
            end
        end
        chk("done_after_last", 32'(w), 10);
        chk("bsy_at_done", 32'(bsy_a), 0);
        @(negedge clk);
        chk("done_one_cycle", 32'(done_a), 0);
        chk("bsy_after",      32'(bsy_a),  0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ifa.trmt === 1'b1) seen++;
        end
        chk("no_extra_trmt", 32'(seen), 0);
        chk("dump_bytes", 32'(bytes_a.size() - base), 98);
        bad = 0;
        for (int i = 0; i < 98 && (base + i) < bytes_a.size(); i++) begin
            expb = (i % 2 == 0) ? 8'hA5 : 8'h3C;
            if (bytes_a[base + i] !== expb) bad++;
        end
        chk("dump_pattern_bad", 32'(bad), 0);
        if (bytes_a.size() > base) chk("dump_first_byte", 32'(bytes_a[base]), 32'hA5);
        chk("done_count", 32'(ndone_a - nd0), 1);

        // ---------------- 20-bit dump: FF FF 0F, strt with final tx_done
        strt_b = 1'b1;
        @(negedge clk);
        strt_b = 1'b0;
        seen = 0;
        for (int b = 0; b < 3; b++) begin
            wait_trmt(1'b1, 200, w);
            if (w < 0) break;
            seen++;
        end
        chk("b_trmt_count", 32'(seen), 3);
        repeat (10) @(negedge clk);     // final tx_done cycle
        strt_b = 1'b1;
        @(negedge clk);
        strt_b = 1'b0;
        chk("b_done",     32'(done_b), 1);
        chk("b_bsy_done", 32'(bsy_b),  0);
        @(negedge clk);
        chk("b_no_restart", 32'(bsy_b),  0);
        chk("b_done_pulse", 32'(done_b), 0);
        chk("b_nbytes", 32'(bytes_b.size()), 3);
        if (bytes_b.size() == 3) begin
            chk("b_byte0", 32'(bytes_b[0]), 32'hFF);
            chk("b_byte1", 32'(bytes_b[1]), 32'hFF);
            chk("b_byte2", 32'(bytes_b[2]), 32'h0F);
        end

        // ---------------- slow UART: tx_data held for 1000 cycles
        dly_a  = 1000;
        strt_a = 1'b1;
        @(negedge clk);
        strt_a = 1'b0;
        wait_trmt(1'b0, 100, w);
        chk("slow_first_trmt", 32'(w), 16);   // cycle 17 counted from cycle 1
        held = ifa.tx_data;
        chk("slow_byte0", 32'(held), 32'hA5);
        bad = 0;
        for (int i = 1; i <= 1001; i++) begin
            @(negedge clk);
            if (ifa.tx_data !== held || ifa.trmt !== 1'b0) bad++;
        end
        chk("slow_hold_bad", 32'(bad), 0);
        chk("slow_bsy", 32'(bsy_a), 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        dly_a = 10;
        @(negedge clk);
        chk("final_idle", 32'(bsy_a), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
